// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if
//   Signal bundle between the UART RX sequencer and its surroundings
//   (line input, configuration, per-bit check results, strobes and
//   end-of-frame pulses).
//   Modports:
//     master - the sequencer: reads line/config/check results,
//              drives counters, strobes and pulses.
//     slave  - the environment: drives line/config/check results,
//              observes counters, strobes and pulses.
//   Parameter PRESCALE_W: width of Prescale and edge_cnt.
interface uart_rx_fsm_if #(
  parameter int unsigned PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  sampled_bit;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  data_samp_en;
  logic                  strt_chk_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  parity_error;
  logic                  framing_error;
  logic                  break_det;

  modport master (
    input  RX_IN, PAR_EN, Prescale, sampled_bit, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, data_samp_en, strt_chk_en, deser_en, par_chk_en,
           stp_chk_en, data_valid, parity_error, framing_error, break_det
  );

  modport slave (
    output RX_IN, PAR_EN, Prescale, sampled_bit, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, data_samp_en, strt_chk_en, deser_en, par_chk_en,
           stp_chk_en, data_valid, parity_error, framing_error, break_det
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
//   Receive-side sequencer for the UART RX path. Tracks frame position
//   with an oversample edge counter and a bit counter, issues one-cycle
//   enables to the start checker, deserializer, parity checker and stop
//   checker, and pulses data_valid / parity_error / framing_error in the
//   IDLE cycle that follows the stop check.
//   Ports:
//     CLK  - oversampling clock
//     RST  - asynchronous active-high reset
//     bus  - uart_rx_fsm_if.master (line, config, check results in;
//            edge_cnt, bit_cnt, strobes and pulses out)
//   Parameters: DATA_WIDTH (1..8 data bits), PRESCALE_W (Prescale width).
//   Optional build macro UART_RX_BREAK_DET_EN: all-zero data with a stop
//   error reports break_det instead of framing_error/parity_error.
module uart_rx_fsm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE  = PRESCALE_W'(4);
  localparam logic [3:0]            LAST_DATA_BIT = 4'(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  par_en_q, par_en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_flag_q, par_flag_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  framing_error_q, framing_error_d;

  logic                  last_edge;
  logic                  is_break;
  logic                  strt_chk_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;

`ifdef UART_RX_BREAK_DET_EN
  logic                  any_one_q, any_one_d;
  logic                  break_det_q, break_det_d;

  // Break: no data bit was ever sampled high and the stop bit failed.
  assign is_break = bus.stp_err && !any_one_q;
`else
  logic                  unused_sampled_bit;

  assign is_break           = 1'b0;
  assign unused_sampled_bit = bus.sampled_bit;
`endif

  assign last_edge = (edge_cnt_q == (prescale_q - PRESCALE_W'(1)));

  always_comb begin
    state_d         = state_q;
    par_en_d        = par_en_q;
    prescale_d      = prescale_q;
    par_flag_d      = par_flag_q;
    data_valid_d    = 1'b0;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;
    strt_chk_en     = 1'b0;
    deser_en        = 1'b0;
    par_chk_en      = 1'b0;
    stp_chk_en      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    any_one_d       = any_one_q;
    break_det_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_d    = START;
          par_en_d   = bus.PAR_EN;
          prescale_d = (bus.Prescale < MIN_PRESCALE) ? MIN_PRESCALE : bus.Prescale;
          par_flag_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          any_one_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (last_edge) begin
          strt_chk_en = 1'b1;
          state_d     = bus.strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        if (last_edge) begin
          deser_en = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          any_one_d = any_one_q | bus.sampled_bit;
`endif
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (last_edge) begin
          par_chk_en = 1'b1;
          par_flag_d = par_flag_q | bus.par_err;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          stp_chk_en      = 1'b1;
          state_d         = IDLE;
          data_valid_d    = !par_flag_q && !bus.stp_err;
          parity_error_d  = par_flag_q && !is_break;
          framing_error_d = bus.stp_err && !is_break;
`ifdef UART_RX_BREAK_DET_EN
          break_det_d     = is_break;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Counters are held at zero in IDLE and cleared on the way back to it,
    // so the first START cycle always sees edge_cnt=0, bit_cnt=0.
    if (state_q == IDLE || state_d == IDLE) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (last_edge) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + 4'd1;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      bit_cnt_d  = bit_cnt_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      edge_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      par_en_q        <= 1'b0;
      prescale_q      <= '0;
      par_flag_q      <= 1'b0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      edge_cnt_q      <= edge_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      par_en_q        <= par_en_d;
      prescale_q      <= prescale_d;
      par_flag_q      <= par_flag_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      any_one_q   <= 1'b0;
      break_det_q <= 1'b0;
    end else begin
      any_one_q   <= any_one_d;
      break_det_q <= break_det_d;
    end
  end

  assign bus.break_det = break_det_q;
`else
  assign bus.break_det = 1'b0;
`endif

  assign bus.edge_cnt      = edge_cnt_q;
  assign bus.bit_cnt       = bit_cnt_q;
  assign bus.data_samp_en  = (state_q != IDLE);
  assign bus.strt_chk_en   = strt_chk_en;
  assign bus.deser_en      = deser_en;
  assign bus.par_chk_en    = par_chk_en;
  assign bus.stp_chk_en    = stp_chk_en;
  assign bus.data_valid    = data_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Receive-side sequencer for the UART RX path.
- Tracks the frame position with an edge counter and a bit counter, and issues one-cycle enables to the data sampler, start checker, deserializer, parity checker and stop checker.
- Collects their error results and pulses data_valid or the error flags at end of frame.
- Sits between the RX_IN pin path and the per-bit check/deserialize blocks, with the same structure as the existing parity checker.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (1..8).
- PRESCALE_W, 6, width of the Prescale input and of edge_cnt.

Ports:
- CLK  input  1  system clock, oversampling rate.
- RST  input  1  reset, asynchronous, active-high.
- RX_IN  input  1  serial line, idle high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- Prescale  input  PRESCALE_W  oversampling ratio, in CLK cycles per bit.
- sampled_bit  input  1  majority-voted bit from the data sampler.
- strt_glitch  input  1  start checker result; valid while strt_chk_en=1.
- par_err  input  1  parity checker result; valid while par_chk_en=1.
- stp_err  input  1  stop checker result; valid while stp_chk_en=1.
- edge_cnt  output  PRESCALE_W  current oversample index within a bit.
- bit_cnt  output  4  current bit index within the frame (0 = start bit).
- data_samp_en  output  1  sampler enable.
- strt_chk_en  output  1  start-check strobe.
- deser_en  output  1  deserializer shift strobe.
- par_chk_en  output  1  parity-check strobe.
- stp_chk_en  output  1  stop-check strobe.
- data_valid  output  1  good-frame pulse.
- parity_error  output  1  parity-fail pulse.
- framing_error  output  1  stop-fail pulse.
- break_det  output  1  break pulse (optional feature below).

Behaviour:
- Reset (RST=1, asynchronous):
  - state=IDLE, edge_cnt=0, bit_cnt=0.
  - All enables and pulses are 0; latched config and error flags are 0.
  - Reset mid-frame abandons the frame and produces no pulse.
- States and transitions:
  - IDLE → START when RX_IN=0 at a CLK edge.
  - START → DATA when the start check passes (strt_glitch=0 during strt_chk_en); START → IDLE when strt_glitch=1, with no error pulse.
  - DATA → PARITY after the last data bit when parity is enabled; DATA → STOP otherwise.
  - PARITY → STOP after the parity check.
  - STOP → IDLE after the stop check.
- Config capture: on the IDLE→START transition, PAR_EN and Prescale are latched. Changes mid-frame are ignored. A Prescale value below 4 is latched as 4.
- Counters:
  - In every non-IDLE state, edge_cnt increments each cycle from 0 and wraps at P-1, where P is the latched Prescale.
  - bit_cnt increments on each wrap and resets to 0 on entry to IDLE.
  - In the first START cycle, edge_cnt=0 and bit_cnt=0.
- Strobes: each strobe is a single cycle, asserted when edge_cnt==P-1 in its state.
  - START: strt_chk_en.
  - DATA: deser_en, once per data bit, for bits 1..DATA_WIDTH.
  - PARITY: par_chk_en.
  - STOP: stp_chk_en.
- data_samp_en = 1 in every state except IDLE.
- Error capture: par_err is captured into a sticky flag during par_chk_en. stp_err is sampled during stp_chk_en.
- End of frame: in the cycle after stp_chk_en, exactly one of the following occurs (state is IDLE in that cycle):
  - data_valid=1 for one cycle, when there is no parity error and no stop error; or
  - parity_error and/or framing_error=1 for one cycle each, as applicable.
- Back-to-back frames: RX_IN=0 in that same IDLE cycle starts the next frame, so no dead cycle is required.
- Line held low after reset: frame reception starts immediately.
- Latency with P=8, parity on, and RX_IN sampled low at cycle T0:
  - strt_chk_en at T0+8.
  - deser_en at T0+16, +24, …, T0+72.
  - par_chk_en at T0+80.
  - stp_chk_en at T0+88.
  - data_valid at T0+89.
- Latency with parity off: stp_chk_en at T0+80, data_valid at T0+81.

Optional Feature:
- UART_RX_BREAK_DET_EN defined:
  - The controller ORs sampled_bit at every deser_en strobe.
  - If all data bits are 0 and stp_err=1, break_det pulses for one cycle in place of framing_error. parity_error is suppressed in that case.
- Macro undefined: break_det is tied 0 and the OR logic is absent.

Test Plan:
- P=8, PAR_EN=1, even parity, byte 0xA5 with correct parity and stop, RX_IN falls at T0 → strobes at the listed cycles; data_valid=1 only at T0+89; both error outputs stay 0.
- P=16, PAR_EN=0, byte 0x3C → stp_chk_en at T0+160, data_valid at T0+161; par_chk_en never asserts.
- Parity mismatch (par_err=1 during par_chk_en), stop good → parity_error pulse at T0+89; data_valid stays 0.
- Start glitch: RX_IN low for 2 cycles, strt_glitch=1 at T0+8 → state IDLE at T0+9; no deser_en; no pulses.
- Two back-to-back frames with the second start bit immediately after the stop bit, plus Prescale changed to 16 mid-frame → first frame still timed at P=8; second frame starts at T0+89 with P=16.
- RST asserted at T0+40 mid-DATA → all outputs 0 immediately; no data_valid; the next frame decodes normally.
- With UART_RX_BREAK_DET_EN: byte 0x00 with stp_err=1 → break_det pulse; framing_error stays 0.
